round_key_scheduler: RTL and testbench
======================================

Name: round_key_scheduler

Overview:
Sequential AES-128 key schedule engine for the SIMD execute stage. It loads a 128-bit cipher key and iterates the single-round key_expansion step once per cycle. It stores all 11 round keys (round 0..10) in an internal register file. The downstream AES round datapath reads them through a registered read port with a 1-cycle latency.

Parameters:
regSize, 32, width of one key word in bits
vecSize, 4, words per round key (fixed at 4 for AES-128)
numRounds, 10, expansion rounds; the register file holds numRounds+1 entries

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new expansion; sampled only in IDLE or DONE
cipher_key  input  [vecSize-1:0][regSize-1:0]  round-0 key; word 0 is the first key word
busy  output  1  expansion in progress
keys_valid  output  1  all 11 round keys stored and stable
rd_en  input  1  read request
rd_addr  input  4  round index 0..10
rd_key  output  [vecSize-1:0][regSize-1:0]  registered read data
rd_valid  output  1  rd_key holds data for the previous cycle's request

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, keys_valid=0, rd_valid=0, rd_key=0.
  - All register-file entries, the working key and the round counter (rnd) are cleared to 0.
- States and transitions:
  - IDLE: start=1 moves to EXPAND.
  - EXPAND: stays for exactly numRounds cycles, then moves to DONE.
  - DONE: start=1 moves back to EXPAND; otherwise holds.
- Start acceptance, on the clock edge where start=1 in IDLE or DONE:
  - key[0] <= cipher_key; working <= cipher_key; rnd <= 0.
  - keys_valid <= 0; busy <= 1.
  - cipher_key is captured only on this edge; later changes are ignored.
- EXPAND, on each edge:
  - key[rnd+1] <= ke_next; working <= ke_next; rnd <= rnd+1.
  - ke_next is the key_expansion output for current_key=working and round=rnd. Round input 0 selects Rcon 0x01.
- Final expansion edge (rnd==numRounds-1):
  - key[10] is written; state <= DONE; busy <= 0; keys_valid <= 1.
- Latency: start sampled at edge E0 gives keys_valid=1 and busy=0 after edge E0+10. busy is high for exactly 10 cycles.
- start while in EXPAND is ignored: no restart and no queueing.
- Restart from DONE: keys_valid drops on the accepting edge. Old entries 1..10 stay readable until overwritten.
- Read port:
  - On an edge with rd_en=1, rd_key <= key[rd_addr] and rd_valid <= 1.
  - On an edge with rd_en=0, rd_valid <= 0 and rd_key holds its value.
  - rd_addr > 10 returns all zeros with rd_valid=1.
- Reads are legal in any state. During EXPAND they return current storage contents.
- Consumers must qualify reads with keys_valid. A read of an entry being written on the same edge returns the old value (read-before-write).
- Reset mid-EXPAND returns to IDLE immediately, with all storage and outputs cleared as in reset.
- Arithmetic: XOR only, no widths wider than regSize. rnd is 4 bits and never exceeds 10.

Decomposition:
- Shared package aes_pkg holds:
  - typedef aes_word_t as logic [31:0];
  - typedef aes_key_t as aes_word_t [3:0];
  - localparam AES_ROUNDS=10;
  - the state enum {IDLE, EXPAND, DONE}.
- Single sub-module: the existing key_expansion. It is instantiated once, combinational, fed from the working key register.
- The register file stays inline; no separate memory module.

Test Plan:
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, pulse start:
  - busy is high for exactly 10 cycles; keys_valid rises 10 cycles after the start edge.
  - Reading addr 1 returns a0fafe17 88542cb1 23a33939 2a6c7605.
  - Reading addr 10 returns d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - Reading addr 0 returns the cipher key.
- Read latency: rd_en with addr 1, 2, 3 in three consecutive cycles gives rd_key equal to the FIPS-197 round keys 1, 2, 3 one cycle later each, with rd_valid high for 3 cycles. rd_addr=12 returns 0 with rd_valid=1.
- start held high throughout EXPAND:
  - Completes in 10 cycles with unchanged results.
  - Restarts from DONE on the next edge and keys_valid drops.
  - Changing cipher_key after the start edge does not affect results.
- Restart with all-zero key from DONE:
  - key[1]=62636363 62636363 62636363 62636363.
  - key[10]=b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- rst_n asserted asynchronously at cycle 5 of EXPAND:
  - Outputs are 0 immediately, without waiting for a clock edge.
  - After release, a read of addr 1 returns 0.
  - A new start produces correct keys.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule types, sizes and FSM state encoding
package aes_pkg;

    localparam int REG_SIZE   = 32;  // bits per key word
    localparam int VEC_SIZE   = 4;   // words per AES-128 round key
    localparam int AES_ROUNDS = 10;  // expansion rounds; storage holds AES_ROUNDS+1 keys

    typedef logic [REG_SIZE-1:0] aes_word_t;
    typedef aes_word_t [VEC_SIZE-1:0] aes_key_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

endpackage

// File: rtl/round_key_scheduler_if.sv
// rtl/round_key_scheduler_if.sv - control, key load and read-port bundle of the key scheduler
//
// start/cipher_key : expansion request and round-0 key (master -> slave)
// busy/keys_valid  : expansion status (slave -> master)
// rd_en/rd_addr    : round-key read request (master -> slave)
// rd_key/rd_valid  : registered read response (slave -> master)
interface round_key_scheduler_if;
    import aes_pkg::*;

    logic       start;
    aes_key_t   cipher_key;
    logic       busy;
    logic       keys_valid;
    logic       rd_en;
    logic [3:0] rd_addr;
    aes_key_t   rd_key;
    logic       rd_valid;

    modport master (
        output start, cipher_key, rd_en, rd_addr,
        input  busy, keys_valid, rd_key, rd_valid
    );

    modport slave (
        input  start, cipher_key, rd_en, rd_addr,
        output busy, keys_valid, rd_key, rd_valid
    );

endinterface

// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - one combinational AES-128 key expansion round
//
// current_key : round key r (word 0 first)
// round       : r, selects Rcon (0 -> 0x01)
// next_key    : round key r+1
module key_expansion
    import aes_pkg::*;
(
    input  aes_key_t   current_key,
    input  logic [3:0] round,
    output aes_key_t   next_key
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic [7:0] rcon;
    aes_word_t  rot;
    aes_word_t  sub;

    always_comb begin
        rcon = 8'h00;
        case (round)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // RotWord then SubWord on the last word of the current key.
    assign rot = {current_key[3][23:0], current_key[3][31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

    assign next_key[0] = current_key[0] ^ sub ^ {rcon, 24'h000000};
    assign next_key[1] = current_key[1] ^ next_key[0];
    assign next_key[2] = current_key[2] ^ next_key[1];
    assign next_key[3] = current_key[3] ^ next_key[2];

endmodule

// File: rtl/round_key_scheduler.sv
// rtl/round_key_scheduler.sv - sequential AES-128 key schedule with 11-entry round-key store
//
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset
// bus   : slave side of round_key_scheduler_if (start/key load, status, read port)
module round_key_scheduler (
    input  logic                        clk,
    input  logic                        rst_n,
    round_key_scheduler_if.slave        bus
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_RND = 4'(AES_ROUNDS - 1);
    localparam logic [3:0] MAX_ADDR = 4'(AES_ROUNDS);

    state_t     state;
    aes_key_t   key_mem [0:AES_ROUNDS];
    aes_key_t   working;
    aes_key_t   ke_next;
    aes_key_t   rd_key_q;
    logic [3:0] rnd;
    logic [3:0] rnd_next;
    logic       busy_q;
    logic       keys_valid_q;
    logic       rd_valid_q;

    assign rnd_next = rnd + 4'd1;

    key_expansion u_key_expansion (
        .current_key (working),
        .round       (rnd),
        .next_key    (ke_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_key_q     <= '0;
            working      <= '0;
            rnd          <= '0;
            for (int i = 0; i <= AES_ROUNDS; i++) begin
                key_mem[i] <= '0;
            end
        end else begin
            // Read port samples storage before this edge's write (read-before-write).
            if (bus.rd_en) begin
                rd_valid_q <= 1'b1;
                rd_key_q   <= (bus.rd_addr <= MAX_ADDR) ? key_mem[bus.rd_addr] : '0;
            end else begin
                rd_valid_q <= 1'b0;
            end

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        key_mem[0]   <= bus.cipher_key;
                        working      <= bus.cipher_key;
                        rnd          <= '0;
                        keys_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state        <= EXPAND;
                    end
                end
                EXPAND: begin
                    key_mem[rnd_next] <= ke_next;
                    working           <= ke_next;
                    rnd               <= rnd_next;
                    if (rnd == LAST_RND) begin
                        state        <= DONE;
                        busy_q       <= 1'b0;
                        keys_valid_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.keys_valid = keys_valid_q;
    assign bus.rd_key     = rd_key_q;
    assign bus.rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_round_key_scheduler.sv
// tb/tb_round_key_scheduler.sv - self-checking bench for round_key_scheduler
module tb_round_key_scheduler;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    round_key_scheduler_if bus ();

    round_key_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] sbox_tbl [0:255];
    aes_key_t   exp_keys [0:10];
    aes_key_t   fips_key;
    aes_key_t   rand_key;
    int         cyc;
    int         busyc;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic aes_key_t mk(input aes_word_t w0, input aes_word_t w1,
                                    input aes_word_t w2, input aes_word_t w3);
        aes_key_t k;
        k[0] = w0;
        k[1] = w1;
        k[2] = w2;
        k[3] = w3;
        return k;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box built by walking the generator 3 and its inverse over GF(2^8).
    task automatic gen_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_tbl[p] = x ^ 8'h63;
        end
        sbox_tbl[0] = 8'h63;
    endtask

    function automatic aes_word_t sub_word(input aes_word_t w);
        return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
    endfunction

    // Textbook 44-word key expansion, then sliced into 11 round keys.
    task automatic build_ref(input aes_key_t ck);
        aes_word_t  w [0:43];
        aes_word_t  t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[i];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = (rc << 1) ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            for (int j = 0; j < 4; j++)
                exp_keys[r][j] = w[4*r + j];
    endtask

    task automatic read_key(input logic [3:0] a, input aes_key_t exp, input string tag);
        @(negedge clk);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        @(negedge clk);
        bus.rd_en = 1'b0;
        check_eq({tag, "_valid"}, 128'(bus.rd_valid), 128'(1));
        check_eq(tag, bus.rd_key, exp);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 11; a++)
            read_key(4'(a), exp_keys[a], $sformatf("%s_k%0d", tag, a));
    endtask

    // Called at the negedge following the start edge (cycle c0); bounded wait for keys_valid.
    task automatic wait_done(input int c0, output int c, output int bc);
        c  = c0;
        bc = bus.busy ? 1 : 0;
        while (!bus.keys_valid && c < 40) begin
            @(negedge clk);
            c++;
            if (bus.busy) bc++;
        end
    endtask

    task automatic pulse_start(input aes_key_t k);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.cipher_key = k;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    function automatic aes_key_t rand_key_gen();
        aes_key_t k;
        for (int j = 0; j < 4; j++) k[j] = $urandom;
        return k;
    endfunction

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.cipher_key = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        gen_sbox();
        fips_key = mk(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);

        repeat (2) @(negedge clk);
        check_eq("rst_busy",       128'(bus.busy),       128'(0));
        check_eq("rst_keys_valid", 128'(bus.keys_valid), 128'(0));
        check_eq("rst_rd_valid",   128'(bus.rd_valid),   128'(0));
        check_eq("rst_rd_key",     bus.rd_key,           128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 vector: latency, busy width and known round keys
        build_ref(fips_key);
        pulse_start(fips_key);
        wait_done(0, cyc, busyc);
        check_eq("fips_latency",   128'(cyc),   128'(10));
        check_eq("fips_busy_cyc",  128'(busyc), 128'(10));
        check_eq("fips_busy_done", 128'(bus.busy), 128'(0));
        read_key(4'd1,  mk(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605), "fips_const_k1");
        read_key(4'd10, mk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6), "fips_const_k10");
        read_key(4'd0,  fips_key, "fips_const_k0");
        read_all("fips");

        // back-to-back reads, one-cycle latency each
        @(negedge clk);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd1;
        for (int a = 1; a <= 3; a++) begin
            @(negedge clk);
            check_eq($sformatf("b2b_valid%0d", a), 128'(bus.rd_valid), 128'(1));
            check_eq($sformatf("b2b_k%0d", a), bus.rd_key, exp_keys[a]);
            bus.rd_addr = 4'(a + 1);
        end
        bus.rd_en = 1'b0;
        @(negedge clk);
        check_eq("b2b_valid_off", 128'(bus.rd_valid), 128'(0));
        check_eq("b2b_hold",      bus.rd_key, exp_keys[3]);
        read_key(4'd12, '0, "addr12");

        // start held high across EXPAND; key changed after the accepting edge
        @(negedge clk);
        bus.start      = 1'b1;
        bus.cipher_key = fips_key;
        @(negedge clk);
        check_eq("hold_kv_drop", 128'(bus.keys_valid), 128'(0));
        check_eq("hold_busy",    128'(bus.busy),       128'(1));
        rand_key       = rand_key_gen();
        bus.cipher_key = rand_key;
        wait_done(0, cyc, busyc);
        check_eq("hold_latency", 128'(cyc),   128'(10));
        check_eq("hold_busy_cyc", 128'(busyc), 128'(10));
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd10;
        @(negedge clk);
        check_eq("hold_k10_unchanged", bus.rd_key, exp_keys[10]);
        check_eq("hold_restart_kv",    128'(bus.keys_valid), 128'(0));
        check_eq("hold_restart_busy",  128'(bus.busy),       128'(1));
        bus.start   = 1'b0;
        bus.rd_addr = 4'd1;
        @(negedge clk);
        check_eq("hold_rbw_k1", bus.rd_key, exp_keys[1]);
        bus.rd_en = 1'b0;
        wait_done(1, cyc, busyc);
        check_eq("restart_latency", 128'(cyc), 128'(10));
        build_ref(rand_key);
        read_all("restart");

        // all-zero key restart from DONE
        build_ref('0);
        pulse_start('0);
        wait_done(0, cyc, busyc);
        read_key(4'd1,  mk(32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363), "zero_const_k1");
        read_key(4'd10, mk(32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e), "zero_const_k10");
        read_all("zero");

        // asynchronous reset in the middle of EXPAND
        build_ref(fips_key);
        @(negedge clk);
        bus.rd_en      = 1'b1;
        bus.rd_addr    = 4'd0;
        bus.start      = 1'b1;
        bus.cipher_key = fips_key;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("prerst_busy",     128'(bus.busy),     128'(1));
        check_eq("prerst_rd_valid", 128'(bus.rd_valid), 128'(1));
        check_eq("prerst_rd_key",   bus.rd_key,         fips_key);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy",       128'(bus.busy),       128'(0));
        check_eq("arst_keys_valid", 128'(bus.keys_valid), 128'(0));
        check_eq("arst_rd_valid",   128'(bus.rd_valid),   128'(0));
        check_eq("arst_rd_key",     bus.rd_key,           128'(0));
        bus.rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        read_key(4'd1, '0, "arst_k1_cleared");
        read_key(4'd0, '0, "arst_k0_cleared");
        check_eq("arst_idle_kv", 128'(bus.keys_valid), 128'(0));
        pulse_start(fips_key);
        wait_done(0, cyc, busyc);
        check_eq("arst_latency", 128'(cyc), 128'(10));
        read_all("after_rst");

        // randomized keys
        for (int n = 0; n < 4; n++) begin
            rand_key = rand_key_gen();
            build_ref(rand_key);
            pulse_start(rand_key);
            wait_done(0, cyc, busyc);
            check_eq($sformatf("rnd%0d_latency", n), 128'(cyc), 128'(10));
            read_all($sformatf("rnd%0d", n));
            read_key(4'($urandom_range(11, 15)), '0, $sformatf("rnd%0d_oob", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
